cpu_alu_regfile: RTL and testbench

- Execute-stage datapath core of the 2-stage 16-bit CPU.
- Contains an 8-entry x 16-bit register file with three combinational read ports (Ra, Rb, Rd) and one synchronous write port.
- Contains an independent combinational 8-op ALU that produces a result and NZCV condition codes.
- The stage-2 decoder drives both halves. It normally feeds rdata_a into alu_a and alu_result into wdata; this block does not make those connections internally.

---
 rtl/cpu_alu_regfile.sv | 112 +++++++++++
 tb/tb_cpu_alu_regfile.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu_regfile.sv
// Execute-stage datapath: 8 x 16-bit register file (3 async read ports, 1 sync write port)
// alongside an independent combinational 8-op ALU with NZCV condition codes.
module cpu_alu_regfile #(
  parameter int DWIDTH  = 16,
  parameter int NREGS   = 8,
  parameter int RAWIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RAWIDTH-1:0] raddr_a,
  output logic [DWIDTH-1:0]  rdata_a,
  input  logic [RAWIDTH-1:0] raddr_b,
  output logic [DWIDTH-1:0]  rdata_b,
  input  logic [RAWIDTH-1:0] raddr_c,
  output logic [DWIDTH-1:0]  rdata_c,
  input  logic               we,
  input  logic [RAWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0]  wdata,
  input  logic [2:0]         alu_op,
  input  logic [DWIDTH-1:0]  alu_a,
  input  logic [DWIDTH-1:0]  alu_b,
  output logic [DWIDTH-1:0]  alu_result,
  output logic [3:0]         alu_cc
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LSL = 3'd5;
  localparam logic [2:0] OP_LSR = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  // ---------------- register file ----------------
  // r0 has no storage; it is decoded to zero on every read port.
  logic [DWIDTH-1:0] regs_q [1:NREGS-1];
  logic [DWIDTH-1:0] regs_d [1:NREGS-1];

  always_comb begin
    for (int i = 1; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (rst) begin
      for (int i = 1; i < NREGS; i++) regs_d[i] = '0;
    end else if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < NREGS; i++) regs_q[i] <= regs_d[i];
  end

  // No write-through bypass: reads always see the pre-edge contents.
  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
  assign rdata_c = (raddr_c == '0) ? '0 : regs_q[raddr_c];

  // ---------------- ALU ----------------
  logic [DWIDTH-1:0]   add_b;
  logic                add_cin;
  logic [DWIDTH:0]     sum;
  logic [3:0]          shamt;
  logic [2*DWIDTH-1:0] lsl_full;
  logic [2*DWIDTH-1:0] lsr_full;
  logic [DWIDTH-1:0]   res;
  logic                flag_c;
  logic                flag_v;

  always_comb begin
    // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
    add_cin  = (alu_op == OP_SUB);
    add_b    = add_cin ? ~alu_b : alu_b;
    sum      = {1'b0, alu_a} + {1'b0, add_b} + {{DWIDTH{1'b0}}, add_cin};
    shamt    = alu_b[3:0];
    // Widened shifts keep the last bit shifted out at a fixed position; it is 0 for amount 0.
    lsl_full = {{DWIDTH{1'b0}}, alu_a} << shamt;
    lsr_full = {alu_a, {DWIDTH{1'b0}}} >> shamt;

    res    = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res    = sum[DWIDTH-1:0];
        flag_c = sum[DWIDTH];
        flag_v = (alu_a[DWIDTH-1] == alu_b[DWIDTH-1]) && (res[DWIDTH-1] != alu_a[DWIDTH-1]);
      end
      OP_SUB: begin
        res    = sum[DWIDTH-1:0];
        flag_c = sum[DWIDTH];
        flag_v = (alu_a[DWIDTH-1] != alu_b[DWIDTH-1]) && (res[DWIDTH-1] != alu_a[DWIDTH-1]);
      end
      OP_AND: res = alu_a & alu_b;
      OP_OR:  res = alu_a | alu_b;
      OP_XOR: res = alu_a ^ alu_b;
      OP_LSL: begin
        res    = lsl_full[DWIDTH-1:0];
        flag_c = lsl_full[DWIDTH];
      end
      OP_LSR: begin
        res    = lsr_full[2*DWIDTH-1:DWIDTH];
        flag_c = lsr_full[DWIDTH-1];
      end
      OP_MOV: res = alu_b;
      default: res = '0;
    endcase
  end

  assign alu_result = res;
  assign alu_cc     = {res[DWIDTH-1], (res == '0), flag_c, flag_v};

endmodule

// File: tb/tb_cpu_alu_regfile.sv
// Self-checking bench for cpu_alu_regfile: directed register-file sequences plus
// table-driven and random ALU vectors checked through an expected-result queue.
module tb_cpu_alu_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  raddr_a, raddr_b, raddr_c;
  logic [15:0] rdata_a, rdata_b, rdata_c;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result;
  logic [3:0]  alu_cc;

  int checks   = 0;
  int failures = 0;

  cpu_alu_regfile dut (
    .clk(clk), .rst(rst),
    .raddr_a(raddr_a), .rdata_a(rdata_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b),
    .raddr_c(raddr_c), .rdata_c(rdata_c),
    .we(we), .waddr(waddr), .wdata(wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cc(alu_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  cc;
  } alu_vec_t;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [3:0]  cc;
  } alu_exp_t;

  alu_vec_t vecs[13];
  alu_exp_t exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  // Reference model from integer arithmetic; flags derived from value ranges.
  task automatic alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic [3:0] cc);
    int ua, ub, sa, sb, s, ss, amt;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = $signed(a); sb = $signed(b);
    amt = int'(b[3:0]);
    c = 1'b0; v = 1'b0; r = 16'h0;
    case (op)
      3'd0: begin s = ua + ub; r = s[15:0]; c = (s > 65535); ss = sa + sb; v = (ss > 32767) || (ss < -32768); end
      3'd1: begin s = ua - ub; r = s[15:0]; c = (ua >= ub);  ss = sa - sb; v = (ss > 32767) || (ss < -32768); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a << amt; c = (amt == 0) ? 1'b0 : a[16 - amt]; end
      3'd6: begin r = a >> amt; c = (amt == 0) ? 1'b0 : a[amt - 1]; end
      default: r = b;
    endcase
    cc = {r[15], (r == 16'h0), c, v};
  endtask

  task automatic alu_apply(input string name, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] r, input logic [3:0] cc);
    alu_exp_t e, got;
    alu_op = op; alu_a = a; alu_b = b;
    e.name = name; e.res = r; e.cc = cc;
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    check({got.name, "_res"}, alu_result, got.res);
    check({got.name, "_cc"}, {12'h0, alu_cc}, {12'h0, got.cc});
  endtask

  task automatic read_all(input string name, input logic [2:0] addr, input logic [15:0] exp);
    raddr_a = addr; raddr_b = addr; raddr_c = addr;
    #1;
    check({name, "_a"}, rdata_a, exp);
    check({name, "_b"}, rdata_b, exp);
    check({name, "_c"}, rdata_c, exp);
  endtask

  logic [15:0] shadow [8];

  initial begin
    logic [15:0] r;
    logic [3:0]  cc;
    logic [2:0]  op;
    logic [15:0] a, b;

    vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
    vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
    vecs[2]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 4'b0110};
    vecs[3]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000};
    vecs[4]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
    vecs[5]  = '{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    vecs[6]  = '{3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100};
    vecs[7]  = '{3'd5, 16'h8001, 16'h0001, 16'h0002, 4'b0010};
    vecs[8]  = '{3'd6, 16'h0003, 16'h0001, 16'h0001, 4'b0010};
    vecs[9]  = '{3'd5, 16'h1234, 16'h0010, 16'h1234, 4'b0000};
    vecs[10] = '{3'd7, 16'h1234, 16'h8000, 16'h8000, 4'b1000};
    vecs[11] = '{3'd3, 16'h8000, 16'h0001, 16'h8001, 4'b1000};
    vecs[12] = '{3'd6, 16'h8000, 16'hFFFF, 16'h0001, 4'b0000};

    rst = 1'b1; we = 1'b0; waddr = 3'd0; wdata = 16'h0;
    raddr_a = 3'd0; raddr_b = 3'd0; raddr_c = 3'd0;
    alu_op = 3'd0; alu_a = 16'h0; alu_b = 16'h0;

    // Reset, then every address reads zero on all ports.
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) read_all($sformatf("rst_r%0d", i), 3'(i), 16'h0);

    // Write to r0 is ignored.
    we = 1'b1; waddr = 3'd0; wdata = 16'h1234;
    @(posedge clk); #1;
    we = 1'b0; raddr_a = 3'd0; #1;
    check("r0_write_ignored", rdata_a, 16'h0);

    // Write r3: old value visible in same cycle, new value after the edge.
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; raddr_b = 3'd3; #1;
    check("r3_same_cycle_old", rdata_b, 16'h0000);
    @(posedge clk); #1;
    we = 1'b0; wdata = 16'hDEAD;
    read_all("r3_after_write", 3'd3, 16'hBEEF);
    @(posedge clk); #1;
    read_all("r3_we0_hold", 3'd3, 16'hBEEF);

    // Fill r1..r7 with distinct values, independent ports read different registers.
    for (int i = 1; i < 8; i++) begin
      shadow[i] = 16'(16'h1111 * i) ^ 16'h0F0F;
      we = 1'b1; waddr = 3'(i); wdata = shadow[i];
      @(posedge clk); #1;
    end
    we = 1'b0;
    for (int i = 1; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'((i % 7) + 1); raddr_c = 3'(8 - i); #1;
      check($sformatf("fill_a_r%0d", i), rdata_a, shadow[i]);
      check($sformatf("fill_b_r%0d", i), rdata_b, shadow[(i % 7) + 1]);
      check($sformatf("fill_c_r%0d", i), rdata_c, shadow[8 - i]);
    end

    // Reset with a concurrent write: write discarded, all registers cleared.
    rst = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'h5555;
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0;
    for (int i = 1; i < 8; i++) read_all($sformatf("midrst_r%0d", i), 3'(i), 16'h0);
    we = 1'b1; waddr = 3'd2; wdata = 16'h5555;
    @(posedge clk); #1;
    we = 1'b0;
    read_all("r2_after_rst", 3'd2, 16'h5555);
    read_all("r1_after_rst", 3'd1, 16'h0);

    // ALU directed table.
    for (int i = 0; i < 13; i++)
      alu_apply($sformatf("alu_vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cc);

    // ALU random vectors against the integer model.
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i % 8 == 0) b = a;
      alu_model(op, a, b, r, cc);
      alu_apply($sformatf("alu_rnd%0d_op%0d", i, op), op, a, b, r, cc);
    end

    check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
